// File: rtl/lift_ctrl_scan_pkg.sv
// Shared types and constants for the SCAN lift controller.
// State codes are plain 2-bit constants so older netlists can match them.
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DN   = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MOVE_UP   = 2'd1;
  localparam logic [1:0] ST_MOVE_DN   = 2'd2;
  localparam logic [1:0] ST_DOOR_OPEN = 2'd3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lift_ctrl_scan_if.sv
// Call inputs and car status outputs between the button decoders and the controller.
// The master side is the decoder/display logic; the slave side is the controller.
interface lift_ctrl_scan_if #(
  parameter int N_FLOORS = 8
) ();
  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;

  logic [N_FLOORS-1:0] hall_req;
  logic [N_FLOORS-1:0] cab_req;
  logic                door_hold;
  logic [FW-1:0]       cur_floor;
  logic                dir_up;
  logic                moving;
  logic                door_open;
  logic                busy;
  logic [N_FLOORS-1:0] pending;

  modport master (
    output hall_req, cab_req, door_hold,
    input  cur_floor, dir_up, moving, door_open, busy, pending
  );

  modport slave (
    input  hall_req, cab_req, door_hold,
    output cur_floor, dir_up, moving, door_open, busy, pending
  );
endinterface

// File: rtl/lift_ctrl_scan_timer.sv
// Loadable down-counter shared by floor travel timing and door dwell timing.
// Holds at zero until reloaded.
module lift_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lift_ctrl_scan.sv
// Single-car lift controller: latches hall/cab calls and serves them in SCAN order.
// state        | meaning
// ST_IDLE      | doors closed, parked, choosing the next direction
// ST_MOVE_UP   | travelling up one floor per timer expiry
// ST_MOVE_DN   | travelling down one floor per timer expiry
// ST_DOOR_OPEN | doors open at cur_floor, dwell timer running
module lift_ctrl_scan
  import lift_pkg::*;
#(
  parameter int N_FLOORS   = 8,
  parameter int HOME_FLOOR = 0,
  parameter int TRAVEL_CYC = 16,
  parameter int DOOR_CYC   = 32
) (
  input logic             clk,
  input logic             rst,
  lift_ctrl_scan_if.slave bus
);

  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
  localparam int TW = $clog2(max_int(TRAVEL_CYC, DOOR_CYC) + 1);

  logic [1:0]          state_q, state_d;
  logic [FW-1:0]       floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [N_FLOORS-1:0] pend_q, pend_d;
  logic [N_FLOORS-1:0] clr;
  logic                ahead_up, ahead_dn;
  logic                beyond_up, beyond_dn;
  logic [FW-1:0]       floor_up, floor_dn;
  logic                tmr_load, tmr_zero;
  logic [TW-1:0]       tmr_val;

  assign floor_up = floor_q + FW'(1);
  assign floor_dn = floor_q - FW'(1);

  // beyond_* is ahead_* seen from the floor the car is about to reach
  always_comb begin
    ahead_up  = 1'b0;
    ahead_dn  = 1'b0;
    beyond_up = 1'b0;
    beyond_dn = 1'b0;
    clr       = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(floor_q))     ahead_up  = ahead_up  | pend_q[i];
      if (i < int'(floor_q))     ahead_dn  = ahead_dn  | pend_q[i];
      if (i > int'(floor_q) + 1) beyond_up = beyond_up | pend_q[i];
      if (i + 1 < int'(floor_q)) beyond_dn = beyond_dn | pend_q[i];
      if ((state_q == ST_DOOR_OPEN) && (i == int'(floor_q))) clr[i] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    pend_d   = (pend_q | bus.hall_req | bus.cab_req) & ~clr;

    case (state_q)
      ST_IDLE: begin
        if (pend_q[floor_q]) begin
          state_d  = ST_DOOR_OPEN;
          tmr_load = 1'b1;
          tmr_val  = TW'(DOOR_CYC - 1);
        end else if ((dir_q && ahead_up) || (!ahead_dn && ahead_up)) begin
          state_d  = ST_MOVE_UP;
          dir_d    = DIR_UP;
          tmr_load = 1'b1;
          tmr_val  = TW'(TRAVEL_CYC - 1);
        end else if (ahead_dn) begin
          state_d  = ST_MOVE_DN;
          dir_d    = DIR_DN;
          tmr_load = 1'b1;
          tmr_val  = TW'(TRAVEL_CYC - 1);
        end
      end
      ST_MOVE_UP: begin
        if (tmr_zero) begin
          floor_d = floor_up;
          if (pend_q[floor_up]) begin
            state_d  = ST_DOOR_OPEN;
            tmr_load = 1'b1;
            tmr_val  = TW'(DOOR_CYC - 1);
          end else if (beyond_up) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(TRAVEL_CYC - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_MOVE_DN: begin
        if (tmr_zero) begin
          floor_d = floor_dn;
          if (pend_q[floor_dn]) begin
            state_d  = ST_DOOR_OPEN;
            tmr_load = 1'b1;
            tmr_val  = TW'(DOOR_CYC - 1);
          end else if (beyond_dn) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(TRAVEL_CYC - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DOOR_OPEN: begin
        // a fresh call at this floor only extends the dwell
        if (bus.door_hold || bus.hall_req[floor_q] || bus.cab_req[floor_q]) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(DOOR_CYC - 1);
        end else if (tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      floor_q <= FW'(HOME_FLOOR);
      dir_q   <= DIR_UP;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
    end
  end

  lift_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  assign bus.cur_floor = floor_q;
  assign bus.dir_up    = dir_q;
  assign bus.moving    = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DN);
  assign bus.door_open = (state_q == ST_DOOR_OPEN);
  assign bus.busy      = (|pend_q) || (state_q != ST_IDLE);
  assign bus.pending   = pend_q;

endmodule

// File: tb/tb_lift_ctrl_scan.sv
// Bench for lift_ctrl_scan: cycle model of the car compared every cycle, plus directed checks.
module tb_lift_ctrl_scan;
  localparam int N    = 8;
  localparam int TRAV = 4;
  localparam int DOOR = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lift_ctrl_scan_if #(.N_FLOORS(N)) bus ();

  lift_ctrl_scan #(
    .N_FLOORS(N), .HOME_FLOOR(0), .TRAVEL_CYC(TRAV), .DOOR_CYC(DOOR)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: mode 0 parked, 1 travelling, 2 doors open; m_left = cycles until the next event
  int         m_mode  = 0;
  int         m_floor = 0;
  bit         m_up    = 1'b1;
  int         m_left  = 0;
  bit [N-1:0] m_pend  = '0;
  bit         m_was_reset = 1'b1;

  function automatic bit any_above(input bit [N-1:0] p, input int f);
    bit r = 1'b0;
    for (int i = f + 1; i < N; i++) r |= p[i];
    return r;
  endfunction

  function automatic bit any_below(input bit [N-1:0] p, input int f);
    bit r = 1'b0;
    for (int i = 0; i < f; i++) r |= p[i];
    return r;
  endfunction

  always @(posedge clk) begin : model
    bit [N-1:0] req;
    bit [N-1:0] old;
    m_was_reset = rst;
    if (rst) begin
      m_mode = 0; m_floor = 0; m_up = 1'b1; m_left = 0; m_pend = '0;
    end else begin
      req = bus.hall_req | bus.cab_req;
      old = m_pend;
      m_pend = m_pend | req;
      if (m_mode == 2) m_pend[m_floor] = 1'b0;
      case (m_mode)
        0: begin
          if (old[m_floor]) begin
            m_mode = 2; m_left = DOOR;
          end else if (any_above(old, m_floor) && (m_up || !any_below(old, m_floor))) begin
            m_mode = 1; m_up = 1'b1; m_left = TRAV;
          end else if (any_below(old, m_floor)) begin
            m_mode = 1; m_up = 1'b0; m_left = TRAV;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_floor = m_up ? m_floor + 1 : m_floor - 1;
            if (old[m_floor]) begin
              m_mode = 2; m_left = DOOR;
            end else if (m_up ? any_above(old, m_floor) : any_below(old, m_floor)) begin
              m_left = TRAV;
            end else begin
              m_mode = 0;
            end
          end
        end
        default: begin
          if (bus.door_hold || req[m_floor]) begin
            m_left = DOOR;
          end else begin
            m_left--;
            if (m_left == 0) m_mode = 0;
          end
        end
      endcase
    end
  end

  logic prev_dir    = 1'b1;
  bit   prev_parked = 1'b1;

  always @(negedge clk) begin : compare
    bit e_busy;
    e_busy = (|m_pend) || (m_mode != 0);
    n_assert++;
    if (int'(bus.cur_floor) != m_floor || bus.dir_up !== m_up ||
        bus.moving !== (m_mode == 1) || bus.door_open !== (m_mode == 2) ||
        bus.busy !== e_busy || bus.pending !== m_pend) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t dut floor=%0d dir=%0b mov=%0b door=%0b busy=%0b pend=%b | model floor=%0d dir=%0b mov=%0b door=%0b busy=%0b pend=%b",
               $time, bus.cur_floor, bus.dir_up, bus.moving, bus.door_open, bus.busy, bus.pending,
               m_floor, m_up, (m_mode == 1), (m_mode == 2), e_busy, m_pend);
    end
    if (bus.dir_up !== prev_dir && !m_was_reset) begin
      n_assert++;
      if (!prev_parked) begin
        n_fail++;
        $display("FAIL dir_change_not_idle t=%0t dir=%0b", $time, bus.dir_up);
      end
    end
    prev_dir    = bus.dir_up;
    prev_parked = !bus.moving && !bus.door_open;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_door(input logic v, input int lim, output int n);
    n = 0;
    while (bus.door_open !== v && n < lim) begin
      tick(1);
      n++;
    end
    if (bus.door_open !== v) begin
      n_assert++; n_fail++;
      $display("FAIL wait_door timeout want=%0b got=%0b", v, bus.door_open);
    end
  endtask

  task automatic wait_floor(input int f, input int lim);
    int n = 0;
    while (int'(bus.cur_floor) != f && n < lim) begin
      tick(1);
      n++;
    end
    if (int'(bus.cur_floor) != f) begin
      n_assert++; n_fail++;
      $display("FAIL wait_floor timeout want=%0d got=%0d", f, bus.cur_floor);
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (bus.busy !== 1'b0 && n < lim) begin
      tick(1);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      n_assert++; n_fail++;
      $display("FAIL wait_idle timeout busy=%0b", bus.busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic pulse_call(input bit hall, input int f);
    if (hall) bus.hall_req[f] = 1'b1;
    else      bus.cab_req[f]  = 1'b1;
    tick(1);
    bus.hall_req = '0;
    bus.cab_req  = '0;
  endtask

  int n;
  int stops[$];
  bit prev_open;

  initial begin
    // 1: reset with calls asserted
    rst = 1'b1;
    bus.hall_req  = '1;
    bus.cab_req   = '1;
    bus.door_hold = 1'b0;
    tick(2);
    chk("rst_floor", int'(bus.cur_floor), 0);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_door", int'(bus.door_open), 0);
    chk("rst_moving", int'(bus.moving), 0);
    chk("rst_dir", int'(bus.dir_up), 1);
    bus.hall_req = '0;
    bus.cab_req  = '0;
    rst = 1'b0;
    tick(1);

    // 2: hall call at floor 3 from floor 0
    bus.hall_req[3] = 1'b1;
    tick(1);
    chk("t2_pend_e1", int'(bus.pending), 8);
    chk("t2_nomove_e1", int'(bus.moving), 0);
    bus.hall_req = '0;
    tick(1);
    chk("t2_move_e2", int'(bus.moving), 1);
    tick(11);
    chk("t2_floor_e13", int'(bus.cur_floor), 2);
    chk("t2_closed_e13", int'(bus.door_open), 0);
    tick(1);
    chk("t2_floor_e14", int'(bus.cur_floor), 3);
    chk("t2_open_e14", int'(bus.door_open), 1);
    wait_door(1'b0, 40, n);
    chk("t2_door_cycles", n, 6);
    chk("t2_pending_clr", int'(bus.pending), 0);
    chk("t2_busy_end", int'(bus.busy), 0);

    // 3: moving up toward 6, cab calls for 1 and 4 raised at floor 2
    do_reset();
    pulse_call(1'b1, 6);
    wait_floor(2, 40);
    bus.cab_req = 8'b0001_0010;
    tick(1);
    bus.cab_req = '0;
    prev_open = 1'b0;
    for (int i = 0; i < 400 && stops.size() < 3; i++) begin
      if (bus.door_open && !prev_open) stops.push_back(int'(bus.cur_floor));
      prev_open = bus.door_open;
      tick(1);
    end
    chk("t3_nstops", stops.size(), 3);
    if (stops.size() == 3) begin
      chk("t3_stop0", stops[0], 4);
      chk("t3_stop1", stops[1], 6);
      chk("t3_stop2", stops[2], 1);
    end
    wait_idle(100);
    chk("t3_dir_end", int'(bus.dir_up), 0);

    // 4: door hold at floor 5, then a hall call at the open floor
    do_reset();
    pulse_call(1'b1, 5);
    wait_door(1'b1, 100, n);
    chk("t4_floor", int'(bus.cur_floor), 5);
    bus.door_hold = 1'b1;
    tick(10);
    chk("t4_held_open", int'(bus.door_open), 1);
    bus.door_hold = 1'b0;
    wait_door(1'b0, 40, n);
    chk("t4_after_release", n, 6);
    pulse_call(1'b0, 5);
    tick(1);
    chk("t4_reopen_e2", int'(bus.door_open), 1);
    tick(2);
    bus.hall_req[5] = 1'b1;
    tick(1);
    chk("t4_call_absorbed", int'(bus.pending), 0);
    bus.hall_req = '0;
    wait_door(1'b0, 40, n);
    chk("t4_reload_cycles", n, 6);
    chk("t4_no_move", int'(bus.moving), 0);

    // 5: boundaries at top and bottom floor
    do_reset();
    pulse_call(1'b1, 7);
    wait_door(1'b1, 200, n);
    chk("t5_top_floor", int'(bus.cur_floor), 7);
    wait_idle(50);
    chk("t5_top_dir", int'(bus.dir_up), 1);
    pulse_call(1'b0, 7);
    tick(1);
    chk("t5_top_open", int'(bus.door_open), 1);
    chk("t5_top_nomove", int'(bus.moving), 0);
    wait_idle(50);
    chk("t5_top_stay", int'(bus.cur_floor), 7);
    pulse_call(1'b1, 0);
    wait_door(1'b1, 200, n);
    chk("t5_bot_floor", int'(bus.cur_floor), 0);
    wait_idle(50);
    chk("t5_bot_dir", int'(bus.dir_up), 0);
    pulse_call(1'b0, 0);
    tick(1);
    chk("t5_bot_open", int'(bus.door_open), 1);
    chk("t5_bot_nomove", int'(bus.moving), 0);
    wait_idle(50);
    chk("t5_bot_stay", int'(bus.cur_floor), 0);

    // 6: reset between floors 2 and 3
    do_reset();
    pulse_call(1'b1, 5);
    wait_floor(2, 40);
    tick(1);
    chk("t6_mid_moving", int'(bus.moving), 1);
    rst = 1'b1;
    tick(1);
    chk("t6_moving", int'(bus.moving), 0);
    chk("t6_floor", int'(bus.cur_floor), 0);
    chk("t6_pending", int'(bus.pending), 0);
    chk("t6_busy", int'(bus.busy), 0);
    rst = 1'b0;
    tick(2);
    chk("t6_stays_idle", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
